regfile_writeback_queue: RTL
============================

Name: regfile_writeback_queue

Overview:
- Write-side front end for the 32x32 three-read-port register file. Accepts results from two producers, the memory stage and the ALU, through valid/ready handshakes.
- Buffers accepted results in a small in-order queue and drains one entry per cycle onto the register file's single write port (LE/RW/PW).
- Gives the issue stage a hazard/forwarding lookup for each of the three read addresses RA, RB and RD.

Parameters:
- DEPTH, 4, number of queue entries (power of two, minimum 2).
- PTR_W, 2, log2(DEPTH); width of the queue pointers.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- mem_valid  input  1  memory-stage result offered.
- mem_rd  input  5  destination register for the memory result.
- mem_data  input  32  memory result data.
- mem_ready  output  1  memory result accepted this cycle when mem_valid is also high.
- alu_valid  input  1  ALU result offered.
- alu_rd  input  5  destination register for the ALU result.
- alu_data  input  32  ALU result data.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
- LE  output  1  register file write enable.
- RW  output  5  register file write address.
- PW  output  32  register file write data.
- RA, RB, RD  input  5 each  lookup addresses (same values as the register file read ports).
- hitA, hitB, hitD  output  1 each  a queued entry targets that address.
- fwdA, fwdB, fwdD  output  32 each  data of the youngest matching queued entry; 0 when there is no hit.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- Reset is synchronous, active-high and has priority over everything in the same cycle. After reset: queue empty, count=0, LE=0, RW=0, PW=0, all hit*=0, all fwd*=0.
- Free slots are computed from the registered count only: free = DEPTH - count. A pop in the same cycle does not create space.
- A result is "effective" when it is offered (valid high) and its destination is not 0.
- A result with rd=0 is accepted but never enqueued: its ready follows the normal rules and it consumes no slot. r0 is hardwired to zero.
- mem_ready = (free >= 1).
- alu_ready = (free >= 2), or (free >= 1 and the memory result is not effective). The memory producer wins a single free slot. alu_ready depends combinationally on mem_valid and mem_rd.
- Enqueue order when both are accepted in one cycle: the memory entry goes in first (older), the ALU entry second.
- Drain: LE = !empty. RW and PW show the head entry when non-empty and are 0 when empty. The head pops on every edge where LE=1, because the register file never stalls.
- Latency: a result accepted at edge N drives LE during cycle N+1 (if the queue was empty) and is written into the register file at edge N+1.
- Simultaneous pop and enqueue: count' = count + pushes - pop. Pointers wrap modulo DEPTH.
- Full queue: both ready outputs are 0 and queue contents are untouched.
- Lookup is combinational over all valid queued entries, including the head currently being written.
  - hitX = (X != 0) and some entry's rd equals X.
  - fwdX = data of the youngest matching entry.
  - Results being offered in the current cycle are not visible to the lookup.
  - Once an entry pops, the register file holds its value from the next cycle, so there is no visibility gap.
- Duplicate destinations in the queue are legal. They drain in order, so the youngest value is written last.

Decomposition:
- Shared header: REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0, and the queue entry layout {rd[4:0], data[31:0]}.
- One sub-module, wbq_lookup: takes the address, the entry array, the valid mask and the head pointer, and returns {hit, data} with youngest-first priority. It is instantiated three times, for A, B and D.

Test Plan:
1. Reset mid-operation with 3 entries queued → next cycle count=0, LE=0, RW=0, PW=0, all hit*=0.
2. Empty queue; mem_valid with rd=5, data=0xDEADBEEF at edge N → cycle N+1: LE=1, RW=5, PW=0xDEADBEEF; with RA=5, hitA=1 and fwdA=0xDEADBEEF. Cycle N+2: LE=0 and hitA=0.
3. count=3 (DEPTH=4), both producers valid with rd=7 and rd=8 → mem_ready=1, alu_ready=0, count becomes 4 (ignoring the concurrent pop). Repeat with mem_rd=0 → alu_ready=1 and the ALU entry is enqueued.
4. Full queue with both producers valid → mem_ready=0, alu_ready=0. After one pop, mem_ready=1 the next cycle.
5. Queue r9=0x1 (mem) and r9=0x2 (alu) in the same cycle, RB=9 → fwdB=0x2. The drain writes 0x1 then 0x2 on consecutive cycles.
6. RA=RB=RD=0 with an entry queued, alu_valid with rd=0 → hit*=0, fwd*=0, alu_ready=1, count unchanged by the ALU result.

Source files
------------

// File: rtl/regfile_writeback_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// A queue entry is {rd, data}; r0 is hardwired to zero and never queued.
package regfile_writeback_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wbq_entry_t;

  // A result only occupies a slot when it is offered and targets a real register.
  function automatic logic is_effective(input logic valid, input logic [REG_ADDR_W-1:0] rd);
    return valid && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer handshakes, register-file write port and hazard lookup bundle.
// The slave modport is the queue; the master modport is the surrounding pipeline.
interface regfile_writeback_queue_if #(
  parameter int PTR_W = 2
);
  import regfile_writeback_queue_pkg::*;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0]     mem_data;
  logic                  mem_ready;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_ready;

  logic                  LE;
  logic [REG_ADDR_W-1:0] RW;
  logic [DATA_W-1:0]     PW;

  logic [REG_ADDR_W-1:0] RA, RB, RD;
  logic                  hitA, hitB, hitD;
  logic [DATA_W-1:0]     fwdA, fwdB, fwdD;

  logic [PTR_W:0]        count;

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, RA, RB, RD,
    output mem_ready, alu_ready, LE, RW, PW, hitA, hitB, hitD, fwdA, fwdB, fwdD, count
  );

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, RA, RB, RD,
    input  mem_ready, alu_ready, LE, RW, PW, hitA, hitB, hitD, fwdA, fwdB, fwdD, count
  );

endinterface

// File: rtl/regfile_writeback_queue_lookup.sv
// Hazard/forwarding lookup over the queue: returns the youngest valid entry
// whose destination matches addr_i. Address 0 never hits.
module wbq_lookup
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  wbq_entry_t            entries_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PTR_W-1:0]      head_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);

  // Walk from oldest (head) to youngest so the last match overrides earlier ones.
  always_comb begin : scan
    logic [PTR_W-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if ((addr_i != REG_ZERO) && valid_i[idx] && (entries_i[idx].rd == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue between the mem/ALU producers and the register file
// write port, with three combinational hazard/forwarding lookups.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic                    clk,
  input logic                    reset,
  regfile_writeback_queue_if.slave bus
);

  localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO   = (PTR_W+1)'(2);

  wbq_entry_t       entries_q [DEPTH];
  wbq_entry_t       entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W:0]   free;
  logic             mem_eff, alu_eff;
  logic             mem_ready, alu_ready;
  logic             mem_push, alu_push, pop;
  logic [PTR_W-1:0] mem_slot, alu_slot;

  // Space is judged from the registered count only; a same-cycle pop never helps.
  assign free      = CNT_DEPTH - count_q;
  assign mem_eff   = is_effective(bus.mem_valid, bus.mem_rd);
  assign alu_eff   = is_effective(bus.alu_valid, bus.alu_rd);
  assign mem_ready = (free >= CNT_ONE);
  assign alu_ready = (free >= CNT_TWO) || ((free >= CNT_ONE) && !mem_eff);

  assign mem_push  = mem_eff && mem_ready;
  assign alu_push  = alu_eff && alu_ready;
  assign pop       = (count_q != '0);

  // Memory result is older, so it takes the tail slot first.
  assign mem_slot  = tail_q;
  assign alu_slot  = tail_q + PTR_W'(mem_push);

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (mem_push) begin
      entries_d[mem_slot] = '{rd: bus.mem_rd, data: bus.mem_data};
      valid_d[mem_slot]   = 1'b1;
    end
    if (alu_push) begin
      entries_d[alu_slot] = '{rd: bus.alu_rd, data: bus.alu_data};
      valid_d[alu_slot]   = 1'b1;
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(mem_push) + PTR_W'(alu_push);
    count_d = count_q + (PTR_W+1)'(mem_push) + (PTR_W+1)'(alu_push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: the valid mask gates every use of it.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.count     = count_q;
  assign bus.LE        = pop;
  assign bus.RW        = pop ? entries_q[head_q].rd   : REG_ZERO;
  assign bus.PW        = pop ? entries_q[head_q].data : '0;

  logic [REG_ADDR_W-1:0] lk_addr [3];
  logic [2:0]            lk_hit;
  logic [DATA_W-1:0]     lk_data [3];

  assign lk_addr[0] = bus.RA;
  assign lk_addr[1] = bus.RB;
  assign lk_addr[2] = bus.RD;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lookup
      wbq_lookup #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
      ) u_lookup (
        .addr_i    (lk_addr[gi]),
        .entries_i (entries_q),
        .valid_i   (valid_q),
        .head_i    (head_q),
        .hit_o     (lk_hit[gi]),
        .data_o    (lk_data[gi])
      );
    end
  endgenerate

  assign bus.hitA = lk_hit[0];
  assign bus.hitB = lk_hit[1];
  assign bus.hitD = lk_hit[2];
  assign bus.fwdA = lk_data[0];
  assign bus.fwdB = lk_data[1];
  assign bus.fwdD = lk_data[2];

endmodule
